// File: rtl/mem_access_unit.sv
// Data-memory access stage between EX/MEM and MEM/WB: issues one req/ack
// transaction per load/store, formats load data and stalls until completion.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        C_MemRead,
  input  logic        C_MemWrite,
  input  logic [1:0]  Size,
  input  logic        LoadUnsigned,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] LoadData,
  output logic        Stall,
  output logic        Misaligned,
  output logic        BusError
);

  // state  | meaning
  // S_IDLE | waiting for a load/store from EX/MEM
  // S_WAIT | request outstanding, counting cycles until ack or timeout
  // S_DONE | one unstalled cycle so the pipeline advances past the access
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        req_d, we_d, mis_d, berr_d;
  logic [31:0] addr_d, wdata_d, load_d;
  logic [3:0]  be_d;

  logic        access, aligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, load_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    access     = C_MemRead | C_MemWrite;
    aligned    = 1'b1;
    lane_be    = 4'b1111;
    lane_wdata = ReadData2;
    case (Size)
      2'b01: begin
        aligned    = ~ALUResult[0];
        lane_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{ReadData2[15:0]}};
      end
      2'b10: begin
        lane_be    = 4'b0001 << ALUResult[1:0];
        lane_wdata = {4{ReadData2[7:0]}};
      end
      default: aligned = (ALUResult[1:0] == 2'b00);
    endcase
  end

  // Formatting uses the offset/size latched at request time, not live inputs.
  always_comb begin
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b01:   load_fmt = uns_q ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'b10:   load_fmt = uns_q ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    be_d    = mem_be;
    wdata_d = mem_wdata;
    load_d  = LoadData;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    Stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (aligned) begin
            Stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = C_MemWrite;
            addr_d  = {ALUResult[31:2], 2'b00};
            be_d    = lane_be;
            wdata_d = lane_wdata;
            size_d  = Size;
            uns_d   = LoadUnsigned;
            off_d   = ALUResult[1:0];
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        Stall = 1'b1;
        // An ack in the final counted cycle still wins over the timeout.
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!mem_we) load_d = load_fmt;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = S_DONE;
          if (!mem_we) load_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      off_q      <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
      LoadData   <= 32'd0;
      Misaligned <= 1'b0;
      BusError   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      mem_req    <= req_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_be     <= be_d;
      mem_wdata  <= wdata_d;
      LoadData   <= load_d;
      Misaligned <= mis_d;
      BusError   <= berr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected request and
// completion records, a negedge monitor pops and compares them.
module tb_mem_access_unit;
  localparam int TMO = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        C_MemRead = 1'b0, C_MemWrite = 1'b0, LoadUnsigned = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] ALUResult = 32'd0, ReadData2 = 32'd0, mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, Stall, Misaligned, BusError;
  logic [31:0] mem_addr, mem_wdata, LoadData;
  logic [3:0]  mem_be;

  always #5 Clk = ~Clk;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .C_MemRead(C_MemRead), .C_MemWrite(C_MemWrite),
    .Size(Size), .LoadUnsigned(LoadUnsigned), .ALUResult(ALUResult),
    .ReadData2(ReadData2), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .LoadData(LoadData),
    .Stall(Stall), .Misaligned(Misaligned), .BusError(BusError)
  );

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;
  typedef struct { bit mis; bit berr; logic [31:0] ld; int stalls; int reqs; } res_t;

  req_t        req_q[$];
  res_t        res_q[$];
  logic [31:0] exp_ld = 32'd0;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  // Reference model: expected bus fields and result from the access rules.
  task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdat, input int delay);
    int          k = int'(addr[1:0]);
    bit          ok;
    int          waits = (delay < TMO) ? delay : TMO;
    logic [31:0] sub;
    req_t        r;
    res_t        e;
    if (sz == 2'd2)      ok = 1'b1;
    else if (sz == 2'd1) ok = (k % 2 == 0);
    else                 ok = (k == 0);
    r.we = wr;
    r.addr = addr & 32'hFFFF_FFFC;
    if (sz == 2'd2) begin
      r.be = 4'(1 << k); r.wdata = {4{wd[7:0]}};
      sub = (rdat >> (8 * k)) & 32'hFF;
      if (!uns && sub[7]) sub = sub | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      r.be = 4'(3 << k); r.wdata = {2{wd[15:0]}};
      sub = (rdat >> (8 * k)) & 32'hFFFF;
      if (!uns && sub[15]) sub = sub | 32'hFFFF_0000;
    end else begin
      r.be = 4'hF; r.wdata = wd; sub = rdat;
    end
    e.mis = !ok; e.berr = 1'b0; e.stalls = 0; e.reqs = 0;
    if (ok) begin
      req_q.push_back(r);
      e.berr = (delay > TMO);
      if (!wr) exp_ld = e.berr ? 32'd0 : sub;
      e.stalls = 1 + waits;
      e.reqs = waits;
    end
    e.ld = exp_ld;
    res_q.push_back(e);

    C_MemRead = rd; C_MemWrite = wr; Size = sz; LoadUnsigned = uns;
    ALUResult = addr; ReadData2 = wd;
    @(posedge Clk); #1;
    C_MemRead = 1'b0; C_MemWrite = 1'b0;
    ALUResult = $urandom; ReadData2 = $urandom; Size = 2'($urandom);
    if (ok) begin
      for (int i = 1; i <= waits; i++) begin
        mem_rdata = (i == delay) ? rdat : $urandom;
        mem_ack = (i == delay);
        @(posedge Clk); #1;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
    end
    repeat ($urandom_range(1, 2)) @(posedge Clk);
    #1;
  endtask

  initial begin : monitor
    bit   stall_prev, req_prev;
    int   stall_cnt, req_cnt;
    req_t r;
    res_t e;
    stall_prev = 0; req_prev = 0; stall_cnt = 0; req_cnt = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        stall_prev = 0; req_prev = 0; stall_cnt = 0; req_cnt = 0;
      end else begin
        if (mem_req && !req_prev) begin
          if (req_q.size() == 0) flag("unexpected_req");
          else begin
            r = req_q.pop_front();
            chk("req_we", 32'(mem_we), 32'(r.we));
            chk("req_addr", mem_addr, r.addr);
            chk("req_be", 32'(mem_be), 32'(r.be));
            chk("req_wdata", mem_wdata, r.wdata);
          end
        end
        if (mem_req) req_cnt++;
        if (Stall) stall_cnt++;
        if (Misaligned) begin
          if (res_q.size() == 0 || !res_q[0].mis) flag("unexpected_misaligned");
          else begin
            e = res_q.pop_front();
            chk("mis_stalls", 32'(stall_cnt), 32'd0);
            chk("mis_reqs", 32'(req_cnt), 32'd0);
            chk("mis_loaddata", LoadData, e.ld);
          end
          stall_cnt = 0; req_cnt = 0;
        end else if (stall_prev && !Stall) begin
          if (res_q.size() == 0 || res_q[0].mis) flag("unexpected_completion");
          else begin
            e = res_q.pop_front();
            chk("done_loaddata", LoadData, e.ld);
            chk("done_buserror", 32'(BusError), 32'(e.berr));
            chk("done_stalls", 32'(stall_cnt), 32'(e.stalls));
            chk("done_req_cycles", 32'(req_cnt), 32'(e.reqs));
          end
          stall_cnt = 0; req_cnt = 0;
        end else if (BusError) flag("spurious_buserror");
        stall_prev = Stall;
        req_prev = mem_req;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    req_t r;
    int   budget;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_loaddata", LoadData, 32'd0);
    chk("rst_flags", {29'd0, Misaligned, BusError, Stall}, 32'd0);
    @(posedge Clk); #1;

    do_access(1, 0, 2'd0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    do_access(1, 0, 2'd2, 0, 32'h103, 32'h0, 32'h80FF1234, 1);
    do_access(1, 0, 2'd2, 1, 32'h103, 32'h0, 32'h80FF1234, 1);
    do_access(0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 32'h0, 3);
    do_access(1, 0, 2'd0, 0, 32'h101, 32'h0, 32'h0, 1);
    do_access(1, 0, 2'd0, 0, 32'h104, 32'h0, 32'h12345678, TMO + 1);
    do_access(1, 0, 2'd1, 1, 32'h10A, 32'h0, 32'hCAFEF00D, TMO);
    do_access(1, 1, 2'd3, 0, 32'h300, 32'h55AA55AA, 32'h0, 1);

    // Reset in the 2nd WAIT cycle, with an ack arriving in that same cycle.
    r.we = 1'b0; r.addr = 32'h400; r.be = 4'hF; r.wdata = 32'h0;
    req_q.push_back(r);
    C_MemRead = 1'b1; Size = 2'd0; ALUResult = 32'h400; ReadData2 = 32'h0;
    @(posedge Clk); #1;
    C_MemRead = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h11112222;
    @(posedge Clk); #1;
    Reset = 1'b0; mem_ack = 1'b0;
    exp_ld = 32'd0;
    chk("wait_rst_mem_req", 32'(mem_req), 32'd0);
    chk("wait_rst_stall", 32'(Stall), 32'd0);
    chk("wait_rst_loaddata", LoadData, exp_ld);
    mem_ack = 1'b1; mem_rdata = 32'h33334444;
    @(posedge Clk); #1;
    mem_ack = 1'b0;
    @(posedge Clk); #1;
    chk("late_ack_loaddata", LoadData, exp_ld);
    chk("late_ack_mem_req", 32'(mem_req), 32'd0);

    for (int n = 0; n < 80; n++) begin
      int op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, 2'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom, $urandom_range(1, TMO + 1));
    end

    budget = 0;
    while ((req_q.size() != 0 || res_q.size() != 0) && budget < 20) begin
      @(posedge Clk);
      budget++;
    end
    #1;
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("res_queue_drained", 32'(res_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
